// File: rtl/regfile_ctrl_pkg.sv
// Shared opcode/state encodings for the register-file access controller.
package regfile_ctrl_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    NOP   = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    COPY  = 3'd3,
    SWAP  = 3'd4,
    CLEAR = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    SWAP2,
    CLR,
    RESP
  } state_e;

endpackage

// File: rtl/regfile_clr_counter.sv
// N-bit sweep counter for CLEAR; done flags the last address while enabled.
module regfile_clr_counter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [N-1:0] cnt,
  output logic         done
);

  always_ff @(posedge clk) begin
    if (reset)   cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end

  // Wrapping back to zero after the last write leaves the counter ready for the next CLEAR.
  assign done = en && (cnt == '1);

endmodule

// File: rtl/regfile_access_ctrl.sv
// Command-driven master for an external 2R/1W register-file RAM.
// Optional ZERO_REG_EN: address 0 reads as zero and is never written.
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [N-1:0]    cmd_addr_a,
  input  logic [N-1:0]    cmd_addr_b,
  input  logic [M-1:0]    cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [M-1:0]    rsp_data_a,
  output logic [M-1:0]    rsp_data_b,
  output logic            rsp_err,
  output logic            ram_we,
  output logic [N-1:0]    ram_ra1,
  output logic [N-1:0]    ram_ra2,
  output logic [N-1:0]    ram_wa,
  output logic [M-1:0]    ram_wd,
  input  logic [M-1:0]    ram_rd1,
  input  logic [M-1:0]    ram_rd2
);

`ifdef ZERO_REG_EN
  localparam bit ZREG = 1'b1;
`else
  localparam bit ZREG = 1'b0;
`endif

  state_e          state, state_nx;
  logic [OP_W-1:0] op_q;
  logic [N-1:0]    a_q, b_q;
  logic [M-1:0]    d_q;
  logic [M-1:0]    rsp_a_q, rsp_b_q;
  logic            err_q;

  logic            load_rsp;
  logic [M-1:0]    nxt_a, nxt_b;
  logic            nxt_err;
  logic            we_raw;
  logic [N-1:0]    wa;
  logic [M-1:0]    wd;
  logic            cnt_en, cnt_done;
  logic [N-1:0]    cnt;
  logic [M-1:0]    rd1, rd2;

  regfile_clr_counter #(.N(N)) u_clr_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .cnt   (cnt),
    .done  (cnt_done)
  );

  assign ram_ra1 = a_q;
  assign ram_ra2 = b_q;
  assign rd1     = (ZREG && a_q == '0) ? '0 : ram_rd1;
  assign rd2     = (ZREG && b_q == '0) ? '0 : ram_rd2;

  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign rsp_data_a = rsp_a_q;
  assign rsp_data_b = rsp_b_q;
  assign rsp_err    = err_q;

  // Reset must kill any in-flight write in the same cycle it is asserted.
  assign ram_we = we_raw && !reset && !(ZREG && wa == '0);
  assign ram_wa = wa;
  assign ram_wd = wd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        op_q <= cmd_op;
        a_q  <= cmd_addr_a;
        b_q  <= cmd_addr_b;
        d_q  <= cmd_data;
      end
      if (load_rsp) begin
        rsp_a_q <= nxt_a;
        rsp_b_q <= nxt_b;
        err_q   <= nxt_err;
      end
    end
  end

  always_comb begin
    state_nx = state;
    load_rsp = 1'b0;
    nxt_a    = '0;
    nxt_b    = '0;
    nxt_err  = 1'b0;
    we_raw   = 1'b0;
    wa       = a_q;
    wd       = d_q;
    cnt_en   = 1'b0;
    case (state)
      IDLE: if (cmd_valid) state_nx = EXEC;
      EXEC: begin
        load_rsp = 1'b1;
        state_nx = RESP;
        case (op_e'(op_q))
          NOP: ;
          READ: begin
            nxt_a = rd1;
            nxt_b = rd2;
          end
          WRITE: begin
            we_raw = 1'b1;
            nxt_a  = d_q;
          end
          COPY: begin
            we_raw = 1'b1;
            wa     = b_q;
            wd     = rd1;
            nxt_a  = rd1;
          end
          // Response regs double as the holding latch for old A written in SWAP2.
          SWAP: begin
            we_raw   = 1'b1;
            wd       = rd2;
            nxt_a    = rd1;
            nxt_b    = rd2;
            state_nx = SWAP2;
          end
          CLEAR: state_nx = CLR;
          default: nxt_err = 1'b1;
        endcase
      end
      SWAP2: begin
        we_raw   = 1'b1;
        wa       = b_q;
        wd       = rsp_a_q;
        state_nx = RESP;
      end
      CLR: begin
        cnt_en = 1'b1;
        we_raw = 1'b1;
        wa     = cnt;
        wd     = '0;
        if (cnt_done) state_nx = RESP;
      end
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench: attached RAM model, abstract reference memory, decoupled response monitor.
module tb_regfile_access_ctrl;

  localparam int N = 2;
  localparam int M = 4;
  localparam int D = 1 << N;

`ifdef ZERO_REG_EN
  localparam bit ZREG = 1'b1;
`else
  localparam bit ZREG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_addr_a, cmd_addr_b, ram_ra1, ram_ra2, ram_wa;
  logic [M-1:0] cmd_data, rsp_data_a, rsp_data_b, ram_wd, ram_rd1, ram_rd2;
  logic         ram_we;

  regfile_access_ctrl #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_err(rsp_err),
    .ram_we(ram_we), .ram_ra1(ram_ra1), .ram_ra2(ram_ra2),
    .ram_wa(ram_wa), .ram_wd(ram_wd), .ram_rd1(ram_rd1), .ram_rd2(ram_rd2)
  );

  // Physical RAM, with a backdoor port used only while the controller is idle.
  logic [M-1:0] mem [D];
  logic         bd_we = 1'b0;
  logic [N-1:0] bd_addr = '0;
  logic [M-1:0] bd_data = '0;
  assign ram_rd1 = mem[ram_ra1];
  assign ram_rd2 = mem[ram_ra2];
  always @(posedge clk) begin
    if (ram_we)     mem[ram_wa]  <= ram_wd;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  int cyc = 0;
  int we_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_we) we_cnt <= we_cnt + 1;

  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         err;
    int           first;
  } exp_t;
  exp_t q[$];

  logic [M-1:0] ref_mem [D];
  int  total = 0;
  int  bad = 0;
  bit  hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [M-1:0] mrd(input int a);
    if (ZREG && a == 0) return '0;
    return ref_mem[a];
  endfunction

  task automatic mwr(input int a, input logic [M-1:0] v);
    if (!(ZREG && a == 0)) ref_mem[a] = v;
  endtask

  // Reference: whole-op semantics applied to an abstract memory; latency in edges after accept.
  task automatic model(input logic [2:0] op, input int a, input int b,
                       input logic [M-1:0] d, input int t, output exp_t e);
    logic [M-1:0] va, vb;
    int lat;
    va = mrd(a);
    vb = mrd(b);
    e.a = '0; e.b = '0; e.err = 1'b0; lat = 2;
    case (op)
      3'd1: begin e.a = va; e.b = vb; end
      3'd2: begin mwr(a, d); e.a = d; end
      3'd3: begin mwr(b, va); e.a = va; end
      3'd4: begin mwr(a, vb); mwr(b, va); e.a = va; e.b = vb; lat = 3; end
      3'd5: begin for (int i = 0; i < D; i++) mwr(i, '0); lat = 2 + D; end
      3'd6, 3'd7: e.err = 1'b1;
      default: ;
    endcase
    // Monitor samples at the falling edge after edge t+lat-1, where rsp_valid first shows.
    e.first = t + lat - 1;
  endtask

  initial begin : monitor
    logic pv;
    logic [M-1:0] ha, hb;
    logic he;
    exp_t e;
    pv = 1'b0; ha = '0; hb = '0; he = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !rsp_valid) begin
        pv = 1'b0;
      end else begin
        if (!pv) begin
          if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
          else chk("rsp_latency", 32'(cyc), 32'(q[0].first));
          ha = rsp_data_a; hb = rsp_data_b; he = rsp_err;
        end else begin
          chk("hold_a", 32'(rsp_data_a), 32'(ha));
          chk("hold_b", 32'(rsp_data_b), 32'(hb));
          chk("hold_err", 32'(rsp_err), 32'(he));
        end
        chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        if (rsp_ready) begin
          pv = 1'b0;
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_a", 32'(rsp_data_a), 32'(e.a));
            chk("rsp_b", 32'(rsp_data_b), 32'(e.b));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
          end
        end else begin
          pv = 1'b1;
        end
      end
    end
  end

  initial begin : ready_drv
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic preload(input int a, input logic [M-1:0] v);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = N'(a); bd_data = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic issue(input logic [2:0] op, input int a, input int b,
                       input logic [M-1:0] d, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_addr_a = N'(a); cmd_addr_b = N'(b); cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (push) begin
      model(op, a, b, d, cyc, e);
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !cmd_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0 || !cmd_ready) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin : stim
    int w0, n;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr_a = '0; cmd_addr_b = '0; cmd_data = '0;
    reset = 1'b1;
    for (int i = 0; i < D; i++) preload(i, '0);
    reset = 1'b0;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_a", 32'(rsp_data_a), 32'd0);
    chk("reset_rsp_b", 32'(rsp_data_b), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);

    // WRITE then READ
    w0 = we_cnt;
    issue(3'd2, 1, 0, 4'hA, 1'b1);
    issue(3'd1, 1, 0, 4'h0, 1'b1);
    drain();
    chk("write_we_count", 32'(we_cnt - w0), 32'd1);

    // SWAP with preloaded words
    preload(0, 4'h3);
    preload(2, 4'hC);
    issue(3'd4, 0, 2, 4'h0, 1'b1);
    drain();
    issue(3'd4, 3, 3, 4'h0, 1'b1);
    issue(3'd3, 2, 2, 4'h0, 1'b1);
    issue(3'd1, 1, 1, 4'h0, 1'b1);
    drain();

    // CLEAR full sweep
    for (int i = 0; i < D; i++) preload(i, 4'hF);
    w0 = we_cnt;
    issue(3'd5, 0, 0, 4'h0, 1'b1);
    drain();
    chk("clear_we_count", 32'(we_cnt - w0), ZREG ? 32'(D - 1) : 32'(D));

    // Backpressure: response held, new command refused
    preload(1, 4'h6);
    hold = 1'b1;
    issue(3'd1, 1, 2, 4'h0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_addr_a = 2'd3; cmd_addr_b = 2'd0; cmd_data = 4'h9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    hold = 1'b0;
    drain();

    // Illegal opcode: error, no write
    w0 = we_cnt;
    issue(3'd7, 1, 2, 4'h5, 1'b1);
    issue(3'd6, 3, 0, 4'h5, 1'b1);
    drain();
    chk("illegal_no_we", 32'(we_cnt - w0), 32'd0);

    // Write to address 0 (suppressed when hardwired zero)
    w0 = we_cnt;
    issue(3'd2, 0, 0, 4'h5, 1'b1);
    issue(3'd1, 0, 1, 4'h0, 1'b1);
    drain();
    chk("addr0_we_count", 32'(we_cnt - w0), ZREG ? 32'd0 : 32'd1);

    // Reset during CLR after two sweep writes
    for (int i = 0; i < D; i++) preload(i, 4'hF);
    w0 = we_cnt;
    issue(3'd5, 0, 0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mwr(0, '0);
    mwr(1, '0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_we_count", 32'(we_cnt - w0), ZREG ? 32'd1 : 32'd2);
    for (int i = 0; i < D; i++) chk("abort_mem", 32'(mem[i]), 32'(ref_mem[i]));

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      issue(3'($urandom_range(0, 7)), $urandom_range(0, D - 1), $urandom_range(0, D - 1),
            M'($urandom_range(0, (1 << M) - 1)), 1'b1);
    end
    drain();
    for (int i = 0; i < D; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
